// File: rtl/imem_responder.sv
// imem_responder: valid/ready instruction-fetch responder with a programmable response latency
// and a side loader port. Defining IMEM_RESP_STATS_EN builds the request/error/stall counters.
module imem_responder #(
    parameter int          DEPTH_WORDS = 4096,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] NOP_WORD    = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    input  logic        ld_we,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data,
    output logic [31:0] stat_req,
    output logic [31:0] stat_err,
    output logic [31:0] stat_stall
);

    localparam int          AW         = $clog2(DEPTH_WORDS);
    localparam logic [32:0] BYTE_LIMIT = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  WAIT_LOAD  = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nxt;
    logic        accept;
    logic        req_err;
    logic        ld_in_range;
    logic [31:0] rd_word;

    logic [31:0] mem [DEPTH_WORDS];

    assign accept      = (state == IDLE) && req_valid;
    assign req_err     = (req_addr[1:0] != 2'b00) || ({1'b0, req_addr} >= BYTE_LIMIT);
    assign ld_in_range = {1'b0, ld_addr} < BYTE_LIMIT;
    assign rd_word     = mem[req_addr[AW+1:2]];

    // Array is never reset so a preloaded image survives a core reset.
    always_ff @(posedge clk) begin
        if (ld_we && ld_in_range) begin
            mem[ld_addr[AW+1:2]] <= ld_data;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (LATENCY == 1) begin
                        state_nxt = RESP;
                    end else begin
                        cnt_nxt   = WAIT_LOAD;
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                // WAIT lasts LATENCY-1 cycles so rsp_valid shows up LATENCY cycles after accept.
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            rsp_data <= 32'd0;
            rsp_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            // Data is captured at accept; later loader writes cannot disturb a pending response.
            if (accept) begin
                rsp_data <= req_err ? NOP_WORD : rd_word;
                rsp_err  <= req_err;
            end
        end
    end

`ifdef IMEM_RESP_STATS_EN
    logic [31:0] cnt_req;
    logic [31:0] cnt_err;
    logic [31:0] cnt_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_req   <= 32'd0;
            cnt_err   <= 32'd0;
            cnt_stall <= 32'd0;
        end else begin
            if (accept) begin
                cnt_req <= cnt_req + 32'd1;
            end
            if (accept && req_err) begin
                cnt_err <= cnt_err + 32'd1;
            end
            if (rsp_valid && !rsp_ready) begin
                cnt_stall <= cnt_stall + 32'd1;
            end
        end
    end

    assign stat_req   = cnt_req;
    assign stat_err   = cnt_err;
    assign stat_stall = cnt_stall;
`else
    assign stat_req   = 32'd0;
    assign stat_err   = 32'd0;
    assign stat_stall = 32'd0;
`endif

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Responder end of the core's instruction-fetch interface.
- Accepts fetch requests (address) from the core's IF stage over a valid/ready handshake.
- Returns the 32-bit instruction word after a configurable latency, replacing the zero-latency combinational imem for stall/latency testing.
- Provides a side write port so a bench or boot loader can preload the program image.

Parameters:
- DEPTH_WORDS, 4096, number of 32-bit words in the array; power of two.
- LATENCY, 2, cycles from request accept to rsp_valid assertion; legal range 1..15.
- NOP_WORD, 32'h00000013, data returned on an error response (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  core presents a fetch request.
- req_ready  out  1  responder can accept a request this cycle.
- req_addr  in  32  byte address of the fetch.
- rsp_valid  out  1  response word is valid.
- rsp_ready  in  1  core consumes the response this cycle.
- rsp_data  out  32  instruction word.
- rsp_err  out  1  the request was misaligned or out of range.
- ld_we  in  1  loader write enable.
- ld_addr  in  32  loader byte address; word-aligned, low 2 bits ignored.
- ld_data  in  32  loader write data.
- stat_req  out  32  accepted-request count (optional feature).
- stat_err  out  32  error-response count (optional feature).
- stat_stall  out  32  count of cycles with rsp_valid=1 and rsp_ready=0 (optional feature).

Behaviour:
- FSM states: IDLE, WAIT, RESP.
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, counter=0, stat_* = 0. Memory contents are not reset.
- Reset asserted mid-operation: return to IDLE immediately; the pending response is dropped and never presented.
- IDLE:
  - req_ready=1.
  - Accept occurs when req_valid=1 in IDLE.
  - On accept, read the array word at req_addr[log2(DEPTH_WORDS)+1:2] and latch it, along with the error flag.
  - Error when req_addr[1:0]!=0 or req_addr >= 4*DEPTH_WORDS. On error, the latched data is NOP_WORD.
  - If LATENCY==1, go to RESP. Otherwise load counter=LATENCY-1 and go to WAIT.
- WAIT:
  - req_ready=0.
  - Decrement the counter each cycle; go to RESP when it reaches 1.
- RESP:
  - rsp_valid=1; rsp_data and rsp_err are held stable until the handshake.
  - When rsp_ready=1, go to IDLE and drop rsp_valid next cycle.
  - req_ready=0 while in RESP; there is no request/response overlap and at most one request outstanding.
- Timing: rsp_valid rises exactly LATENCY cycles after the accept edge.
- Read-after-write timing: read data is captured at accept.
  - A loader write to the same word in the accept cycle does not affect that response; old data is returned.
  - A loader write after accept also does not affect the pending response.
- Loader writes:
  - Always allowed in any state.
  - Take effect at the clock edge.
  - ld_addr beyond DEPTH_WORDS is ignored; no wrap.
- req_addr is sampled only at accept; changes while req_ready=0 are ignored.
- rsp_ready while rsp_valid=0 is ignored.

Optional Feature:
- Macro IMEM_RESP_STATS_EN.
- Defined:
  - stat_req increments on each accept.
  - stat_err increments on each accepted erroneous request.
  - stat_stall increments each cycle with rsp_valid=1 and rsp_ready=0.
  - All three wrap modulo 2^32 and reset to 0.
- Undefined: no counter logic; stat_req, stat_err and stat_stall are tied to 0.

Test Plan:
- Preload word 0=0x00500093 and word 1=0x00A00113; request addr 0x0, rsp_ready=1 -> rsp_valid exactly 2 cycles after accept, rsp_data=0x00500093, rsp_err=0. Request addr 0x4 -> 0x00A00113.
- Request addr 0x6 -> rsp_err=1, rsp_data=0x00000013. Request addr 0x4000 with DEPTH_WORDS=4096 -> rsp_err=1, data=0x00000013.
- Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_data stable, req_ready=0 throughout, new req_valid ignored. With IMEM_RESP_STATS_EN, stat_stall=5.
- Loader writes 0xDEADBEEF to word 2 in the same cycle a request for addr 0x8 (old value 0x11111111) is accepted -> response is 0x11111111; the next request for 0x8 returns 0xDEADBEEF.
- Assert rst during WAIT -> rsp_valid stays 0, req_ready=1 the next cycle, preloaded memory intact (re-fetch of 0x0 returns 0x00500093).
- LATENCY=1 build, back-to-back requests with rsp_ready=1 -> one response every 2 cycles. With IMEM_RESP_STATS_EN, after 10 requests with 3 errors: stat_req=10, stat_err=3.
